// File: rtl/aes_pkg.sv
// Shared AES-128 constants and byte-level round primitives for the iterative core.
// Bytes are big-endian: byte 0 of a block sits in [127:120], columns are bytes 4c..4c+3.
package aes_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;

    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_FLAT[(11'd2047 - {b, 3'b000}) -: 8];
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return r;
    endfunction

    // Row r of column c takes the byte from column (c+r) mod 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[127-8*(w+4*c) -: 8] = s[127-8*(w+4*((c+w)%4)) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] w, input logic [7:0] rc);
        logic [31:0] rot, t, w0, w1, w2, w3;
        rot = {w[23:0], w[31:24]};
        t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rc, 24'h0};
        w0  = w[127:96] ^ t;
        w1  = w[95:64] ^ w0;
        w2  = w[63:32] ^ w1;
        w3  = w[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_round_dp.sv
// One AES round plus the matching round-key step, purely combinational.
// The final round bypasses MixColumns.
module aes_round_dp
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] rkey,
    input  logic [7:0]   rcon,
    input  logic         last,
    output logic [127:0] next_state,
    output logic [127:0] next_key
);

    logic [127:0] sr;
    logic [127:0] mc;

    assign sr         = shift_rows(sub_bytes(state));
    assign mc         = last ? sr : mix_columns(sr);
    assign next_key   = key_step(rkey, rcon);
    assign next_state = mc ^ next_key;

endmodule

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryptor: one shared round datapath, on-the-fly key expansion,
// valid/ready on both sides and optional wait states per round.
module aes128_iter_core
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS   = 10,
    parameter int STAGE_CYCLES = 1
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] pt_in,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ct_out,
    output logic         busy,
    output logic [3:0]   round_idx
);

    localparam logic [3:0] ROUND_LAST = 4'(NUM_ROUNDS);
    localparam logic [2:0] CYC_LAST   = 3'(STAGE_CYCLES - 1);

    fsm_t         fsm_q, fsm_d;
    logic [127:0] st_q, rk_q;
    logic [3:0]   rnd_q;
    logic [2:0]   cyc_q;
    logic [127:0] dp_state, dp_key;
    logic         step;

    assign step = (cyc_q == CYC_LAST);

    aes_round_dp u_round (
        .state      (st_q),
        .rkey       (rk_q),
        .rcon       (rcon_of(rnd_q)),
        .last       (rnd_q == ROUND_LAST),
        .next_state (dp_state),
        .next_key   (dp_key)
    );

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE:  if (in_valid) fsm_d = S_RUN;
            S_RUN:   if (step && rnd_q == ROUND_LAST) fsm_d = S_DONE;
            S_DONE:  if (out_ready) fsm_d = S_IDLE;
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            fsm_q <= S_IDLE;
            st_q  <= '0;
            rk_q  <= '0;
            rnd_q <= '0;
            cyc_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            case (fsm_q)
                S_IDLE: if (in_valid) begin
                    st_q  <= pt_in ^ key_in;
                    rk_q  <= key_in;
                    rnd_q <= 4'd1;
                    cyc_q <= '0;
                end
                S_RUN: if (step) begin
                    st_q  <= dp_state;
                    rk_q  <= dp_key;
                    cyc_q <= '0;
                    // round_idx parks on the last round while the result waits in DONE
                    if (rnd_q != ROUND_LAST) rnd_q <= rnd_q + 4'd1;
                end else begin
                    cyc_q <= cyc_q + 3'd1;
                end
                S_DONE: if (out_ready) rnd_q <= '0;
                default: ;
            endcase
        end
    end

    assign in_ready  = (fsm_q == S_IDLE);
    assign out_valid = (fsm_q == S_DONE);
    assign busy      = (fsm_q != S_IDLE);
    assign ct_out    = st_q;
    assign round_idx = rnd_q;

endmodule

// File: tb/tb_aes128_iter_core.sv
// Bench for aes128_iter_core: three parameterisations checked every cycle against a
// byte-level AES model whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes128_iter_core;

    localparam int NR[3] = '{10, 10, 1};
    localparam int SC[3] = '{1, 3, 1};

    logic         clock = 1'b0;
    logic         rst;
    logic [127:0] pt_in, key_in;
    logic         in_valid[3], out_ready[3];
    logic         in_ready[3], out_valid[3], busy[3];
    logic [127:0] ct_out[3];
    logic [3:0]   round_idx[3];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    aes128_iter_core #(.NUM_ROUNDS(10), .STAGE_CYCLES(1)) u_dut0 (
        .clock(clock), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .pt_in(pt_in), .key_in(key_in), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .ct_out(ct_out[0]), .busy(busy[0]), .round_idx(round_idx[0]));

    aes128_iter_core #(.NUM_ROUNDS(10), .STAGE_CYCLES(3)) u_dut1 (
        .clock(clock), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .pt_in(pt_in), .key_in(key_in), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .ct_out(ct_out[1]), .busy(busy[1]), .round_idx(round_idx[1]));

    aes128_iter_core #(.NUM_ROUNDS(1), .STAGE_CYCLES(1)) u_dut2 (
        .clock(clock), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .pt_in(pt_in), .key_in(key_in), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .ct_out(ct_out[2]), .busy(busy[2]), .round_idx(round_idx[2]));

    // ---------------- reference model ----------------
    logic [7:0] sb[256];

    function automatic logic [7:0] xt(logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00, x = a, y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, c, o;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                o[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb[x] = o;
        end
    endtask

    function automatic logic [127:0] aes_ref(logic [127:0] key, logic [127:0] pt, int nr);
        logic [7:0] s[16], k[16], t[16], tmp[4], rc, a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) begin
            k[i] = key[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ k[i];
        end
        for (int r = 1; r <= nr; r++) begin
            tmp[0] = sb[k[13]] ^ rc; tmp[1] = sb[k[14]]; tmp[2] = sb[k[15]]; tmp[3] = sb[k[12]];
            for (int j = 0; j < 4; j++) k[j] ^= tmp[j];
            for (int i = 4; i < 16; i++) k[i] ^= k[i-4];
            rc = xt(rc);
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) t[w+4*c] = sb[s[w+4*((c+w)%4)]];
            if (r != nr)
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
                    t[4*c+3] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
                end
            for (int i = 0; i < 16; i++) s[i] = t[i] ^ k[i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tmo(string name);
        checks++;
        errors++;
        $display("FAIL %s timeout", name);
    endtask

    // ---------------- scoreboard: one block in flight per DUT ----------------
    int           cyc = 0;
    bit           rst_seen = 1'b0;
    bit           pend[3] = '{0, 0, 0};
    int           acc[3];
    logic [127:0] exp_ct[3];
    int           rises[$];
    logic         ov_prev = 1'b0;

    always @(posedge clock) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
        for (int k = 0; k < 3; k++) begin
            if (rst) pend[k] <= 1'b0;
            else if (in_valid[k] && in_ready[k]) begin
                pend[k]   <= 1'b1;
                acc[k]    <= cyc + 1;
                exp_ct[k] <= aes_ref(key_in, pt_in, NR[k]);
            end else if (out_valid[k] && out_ready[k]) pend[k] <= 1'b0;
        end
    end

    always @(negedge clock) begin
        int e, rd;
        bit ov;
        if (cyc > 0) begin
            for (int k = 0; k < 3; k++) begin
                if (rst_seen) begin
                    chk($sformatf("rst d%0d in_ready", k), 128'(in_ready[k]), 128'd1);
                    chk($sformatf("rst d%0d out_valid", k), 128'(out_valid[k]), 128'd0);
                    chk($sformatf("rst d%0d busy", k), 128'(busy[k]), 128'd0);
                    chk($sformatf("rst d%0d round_idx", k), 128'(round_idx[k]), 128'd0);
                    chk($sformatf("rst d%0d ct_out", k), ct_out[k], 128'd0);
                end else begin
                    e  = cyc - acc[k];
                    ov = pend[k] && (e >= NR[k] * SC[k]);
                    rd = !pend[k] ? 0 : (ov ? NR[k] : e / SC[k] + 1);
                    chk($sformatf("d%0d in_ready", k), 128'(in_ready[k]), 128'(!pend[k]));
                    chk($sformatf("d%0d busy", k), 128'(busy[k]), 128'(pend[k]));
                    chk($sformatf("d%0d out_valid", k), 128'(out_valid[k]), 128'(ov));
                    chk($sformatf("d%0d round_idx", k), 128'(round_idx[k]), 128'(rd));
                    if (ov) chk($sformatf("d%0d ct_out", k), ct_out[k], exp_ct[k]);
                end
            end
            if (!rst_seen && out_valid[0] && !ov_prev) rises.push_back(cyc);
            ov_prev <= out_valid[0];
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(int k, logic [127:0] kk, logic [127:0] pp);
        int n = 0;
        key_in = kk; pt_in = pp; in_valid[k] = 1'b1;
        while (!in_ready[k] && n < 60) begin @(negedge clock); n++; end
        if (n >= 60) tmo($sformatf("d%0d accept", k));
        @(negedge clock);
        in_valid[k] = 1'b0;
    endtask

    task automatic wait_out(int k);
        int n = 0;
        while (!out_valid[k] && n < 100) begin @(negedge clock); n++; end
        if (n >= 100) tmo($sformatf("d%0d out_valid", k));
    endtask

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C3 = 128'h01000000010000000100000001000000;

    initial begin
        logic [127:0] held;
        int n, n0, sz;
        rst = 1'b1; pt_in = '0; key_in = '0;
        for (int k = 0; k < 3; k++) begin in_valid[k] = 1'b0; out_ready[k] = 1'b1; end
        build_sbox();
        chk("model fips", aes_ref(K1, P1, 10), C1);
        chk("model sp800", aes_ref(K2, P2, 10), C2);
        chk("model nr1 zero", aes_ref('0, '0, 1), C3);
        repeat (3) @(negedge clock);
        rst = 1'b0;
        @(negedge clock);

        send(0, K1, P1);
        wait_out(0);
        chk("dut0 fips ct", ct_out[0], C1);
        chk("dut0 latency", 128'(cyc - acc[0]), 128'd10);

        send(1, K2, P2);
        wait_out(1);
        chk("dut1 sc3 ct", ct_out[1], C2);
        chk("dut1 latency", 128'(cyc - acc[1]), 128'd30);

        send(2, '0, '0);
        wait_out(2);
        chk("dut2 nr1 ct", ct_out[2], C3);
        @(negedge clock);

        // Backpressure: hold the result while stray in_valid pulses arrive
        out_ready[0] = 1'b0;
        send(0, K2, P2);
        wait_out(0);
        held = ct_out[0];
        chk("bp held ct", held, C2);
        for (int i = 0; i < 7; i++) begin
            in_valid[0] = i[0];
            pt_in = ~pt_in;
            @(negedge clock);
            chk("bp ct stable", ct_out[0], held);
            chk("bp ov stable", 128'(out_valid[0]), 128'd1);
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clock);
        chk("bp in_ready after xfer", 128'(in_ready[0]), 128'd1);
        chk("bp ov dropped", 128'(out_valid[0]), 128'd0);

        // Abort at round 5, then a fresh block must still come out right
        send(0, K1, P1);
        n = 0;
        while (round_idx[0] != 4'd5 && n < 20) begin @(negedge clock); n++; end
        if (n >= 20) tmo("round5");
        rst = 1'b1;
        repeat (2) @(negedge clock);
        rst = 1'b0;
        n0 = rises.size();
        repeat (15) @(negedge clock);
        chk("abort no output", 128'(rises.size()), 128'(n0));
        send(0, K2, P2);
        wait_out(0);
        chk("post-abort ct", ct_out[0], C2);
        @(negedge clock);

        // Back-to-back with in_valid held high
        in_valid[0] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            pt_in  = {$urandom(), $urandom(), $urandom(), $urandom()};
            key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            n = 0;
            while (!in_ready[0] && n < 60) begin @(negedge clock); n++; end
            if (n >= 60) tmo("b2b accept");
            @(negedge clock);
        end
        in_valid[0] = 1'b0;
        wait_out(0);
        repeat (3) @(negedge clock);
        sz = rises.size();
        if (sz >= 4) begin
            for (int i = 1; i < 4; i++)
                chk($sformatf("b2b spacing %0d", i), 128'(rises[sz-4+i] - rises[sz-5+i]), 128'd12);
        end else tmo("b2b rises");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
